// File: rtl/rename_regfile_mp_pkg.sv
// Shared sizing and types for the renamed architectural register file.
package rename_regfile_mp_pkg;
  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int RW     = $clog2(NREG);
  localparam int TAG_W  = 5;
  localparam int DISP_W = 2;
  localparam int CMT_W  = 2;

  typedef logic [XLEN-1:0]  data_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [RW-1:0]    reg_t;

  // Tag 0 means the register holds its committed value.
  localparam tag_t TAG_NONE = '0;
endpackage

// File: rtl/rename_regfile_mp_if.sv
// Dispatch/commit bus between dispatcher+ROB (master) and the register file (slave).
interface rename_regfile_mp_if;
  import rename_regfile_mp_pkg::*;

  logic                     rdy;
  logic                     flush;
  logic [CMT_W-1:0]         cmt_valid;
  reg_t  [CMT_W-1:0]        cmt_dest;
  tag_t  [CMT_W-1:0]        cmt_tag;
  data_t [CMT_W-1:0]        cmt_data;
  logic [DISP_W-1:0]        dsp_valid;
  reg_t  [DISP_W-1:0]       dsp_rd;
  tag_t  [DISP_W-1:0]       dsp_tag;
  reg_t  [DISP_W-1:0]       dsp_rs1;
  reg_t  [DISP_W-1:0]       dsp_rs2;
  tag_t  [DISP_W-1:0]       dsp_q1;
  tag_t  [DISP_W-1:0]       dsp_q2;
  data_t [DISP_W-1:0]       dsp_v1;
  data_t [DISP_W-1:0]       dsp_v2;

  modport master (
    output rdy, flush, cmt_valid, cmt_dest, cmt_tag, cmt_data,
           dsp_valid, dsp_rd, dsp_tag, dsp_rs1, dsp_rs2,
    input  dsp_q1, dsp_q2, dsp_v1, dsp_v2
  );
  modport slave (
    input  rdy, flush, cmt_valid, cmt_dest, cmt_tag, cmt_data,
           dsp_valid, dsp_rd, dsp_tag, dsp_rs1, dsp_rs2,
    output dsp_q1, dsp_q2, dsp_v1, dsp_v2
  );
endinterface

// File: rtl/rename_regfile_mp_rf_read_bypass.sv
// One source-operand read port: x0, in-bundle rename, commit bypass, then array value.
module rf_read_bypass
  import rename_regfile_mp_pkg::*;
#(
  parameter int LANE = 0
) (
  input  reg_t                     src,
  input  tag_t                     tag_s,
  input  data_t                    data_s,
  input  logic  [DISP_W-1:0]       dsp_valid,
  input  reg_t  [DISP_W-1:0]       dsp_rd,
  input  tag_t  [DISP_W-1:0]       dsp_tag,
  input  logic  [CMT_W-1:0]        cmt_valid,
  input  reg_t  [CMT_W-1:0]        cmt_dest,
  input  tag_t  [CMT_W-1:0]        cmt_tag,
  input  data_t [CMT_W-1:0]        cmt_data,
  output tag_t                     q,
  output data_t                    v
);
  // Rules are applied lowest priority first so later assignments override.
  always_comb begin
    q = tag_s;
    v = data_s;
    for (int c = 0; c < CMT_W; c++) begin
      if (cmt_valid[c] && cmt_dest[c] == src && cmt_tag[c] == tag_s) begin
        q = TAG_NONE;
        v = cmt_data[c];
      end
    end
    // Only older lanes in the bundle can rename our source.
    for (int e = 0; e < LANE; e++) begin
      if (dsp_valid[e] && dsp_rd[e] == src) begin
        q = dsp_tag[e];
        v = '0;
      end
    end
    if (src == '0) begin
      q = TAG_NONE;
      v = '0;
    end
  end
endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-ported register file with per-register ROB tag, commit bypass and in-bundle forwarding.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
(
  input logic               clk,
  input logic               rst,
  rename_regfile_mp_if.slave bus
);
  data_t [NREG-1:0] data_q, data_nxt;
  tag_t  [NREG-1:0] tag_q,  tag_nxt;

  // Ascending lane loops make the highest lane win on collisions; dispatch is
  // applied after commit clears so a same-cycle rename is never lost.
  always_comb begin
    data_nxt = data_q;
    tag_nxt  = tag_q;
    for (int c = 0; c < CMT_W; c++) begin
      if (bus.cmt_valid[c] && bus.cmt_dest[c] != '0) begin
        data_nxt[bus.cmt_dest[c]] = bus.cmt_data[c];
        if (bus.cmt_tag[c] == tag_q[bus.cmt_dest[c]])
          tag_nxt[bus.cmt_dest[c]] = TAG_NONE;
      end
    end
    if (bus.flush) begin
      tag_nxt = '0;
    end else begin
      for (int d = 0; d < DISP_W; d++) begin
        if (bus.dsp_valid[d] && bus.dsp_rd[d] != '0)
          tag_nxt[bus.dsp_rd[d]] = bus.dsp_tag[d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      tag_q  <= '0;
    end else if (bus.rdy) begin
      data_q <= data_nxt;
      tag_q  <= tag_nxt;
    end
  end

  tag_t  [DISP_W-1:0] q1, q2;
  data_t [DISP_W-1:0] v1, v2;

  for (genvar d = 0; d < DISP_W; d++) begin : g_lane
    rf_read_bypass #(.LANE(d)) u_rs1 (
      .src(bus.dsp_rs1[d]), .tag_s(tag_q[bus.dsp_rs1[d]]), .data_s(data_q[bus.dsp_rs1[d]]),
      .dsp_valid(bus.dsp_valid), .dsp_rd(bus.dsp_rd), .dsp_tag(bus.dsp_tag),
      .cmt_valid(bus.cmt_valid), .cmt_dest(bus.cmt_dest), .cmt_tag(bus.cmt_tag),
      .cmt_data(bus.cmt_data), .q(q1[d]), .v(v1[d])
    );
    rf_read_bypass #(.LANE(d)) u_rs2 (
      .src(bus.dsp_rs2[d]), .tag_s(tag_q[bus.dsp_rs2[d]]), .data_s(data_q[bus.dsp_rs2[d]]),
      .dsp_valid(bus.dsp_valid), .dsp_rd(bus.dsp_rd), .dsp_tag(bus.dsp_tag),
      .cmt_valid(bus.cmt_valid), .cmt_dest(bus.cmt_dest), .cmt_tag(bus.cmt_tag),
      .cmt_data(bus.cmt_data), .q(q2[d]), .v(v2[d])
    );
  end

  assign bus.dsp_q1 = q1;
  assign bus.dsp_q2 = q2;
  assign bus.dsp_v1 = v1;
  assign bus.dsp_v2 = v2;
endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed scoreboard bench for rename_regfile_mp.
module tb_rename_regfile_mp;
  import rename_regfile_mp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rename_regfile_mp_if bus();
  rename_regfile_mp dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    string name;
    int    lane;
    int    port;
    tag_t  q;
    data_t v;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.cmt_valid = '0; bus.cmt_dest = '0; bus.cmt_tag = '0; bus.cmt_data = '0;
    bus.dsp_valid = '0; bus.dsp_rd = '0; bus.dsp_tag = '0;
    bus.dsp_rs1 = '0; bus.dsp_rs2 = '0;
  endtask

  task automatic cmt(int c, int dest, int tag, data_t d);
    bus.cmt_valid[c] = 1'b1; bus.cmt_dest[c] = reg_t'(dest);
    bus.cmt_tag[c] = tag_t'(tag); bus.cmt_data[c] = d;
  endtask

  task automatic dsp(int l, int rd, int tag);
    bus.dsp_valid[l] = 1'b1; bus.dsp_rd[l] = reg_t'(rd); bus.dsp_tag[l] = tag_t'(tag);
  endtask

  task automatic rd(string n, int l, int port, int src, int q, data_t v);
    exp_t e;
    if (port == 1) bus.dsp_rs1[l] = reg_t'(src);
    else           bus.dsp_rs2[l] = reg_t'(src);
    e.name = n; e.lane = l; e.port = port; e.q = tag_t'(q); e.v = v;
    sb.push_back(e);
  endtask

  // Let combinational reads settle, then drain the scoreboard.
  task automatic check();
    exp_t  e;
    tag_t  oq;
    data_t ov;
    #1;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      oq = (e.port == 1) ? bus.dsp_q1[e.lane] : bus.dsp_q2[e.lane];
      ov = (e.port == 1) ? bus.dsp_v1[e.lane] : bus.dsp_v2[e.lane];
      total++;
      assert (oq === e.q) passed++;
      else $error("FAIL %s.q lane%0d rs%0d: got %0d want %0d", e.name, e.lane, e.port, oq, e.q);
      total++;
      assert (ov === e.v) passed++;
      else $error("FAIL %s.v lane%0d rs%0d: got 0x%0h want 0x%0h", e.name, e.lane, e.port, ov, e.v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clk);
    rd("rst_r5", 0, 1, 5, 0, 0);
    rd("rst_r5", 1, 1, 5, 0, 0);
    check();
    rst = 1'b1;
    @(negedge clk);

    // x0 is never written
    cmt(0, 0, 0, 32'hFFFF);
    rd("r0_bypass", 0, 1, 0, 0, 0);
    check();
    step();
    rd("r0_after", 0, 2, 0, 0, 0);
    check();

    // rename, then commit with same-cycle bypass
    dsp(0, 3, 7);
    step();
    rd("r3_renamed", 0, 1, 3, 7, 0);
    check();
    cmt(0, 3, 7, 32'h55);
    rd("r3_bypass", 0, 1, 3, 0, 32'h55);
    check();
    step();
    rd("r3_committed", 1, 2, 3, 0, 32'h55);
    check();

    // in-bundle forwarding and dispatch collision
    dsp(0, 4, 2);
    dsp(1, 4, 3);
    rd("r4_fwd", 1, 1, 4, 2, 0);
    rd("r4_no_self", 0, 1, 4, 0, 0);
    check();
    step();
    rd("r4_collide", 0, 2, 4, 3, 0);
    check();

    // stale commit writes data but keeps newer tag
    dsp(0, 6, 9);
    step();
    cmt(1, 6, 4, 32'h11);
    rd("r6_stale_byp", 0, 1, 6, 9, 0);
    check();
    step();
    rd("r6_stale", 1, 1, 6, 9, 32'h11);
    check();

    // commit clear loses to same-cycle dispatch of the same register
    dsp(1, 8, 5);
    step();
    cmt(0, 8, 5, 32'hAB);
    dsp(0, 8, 12);
    rd("r8_cmt_byp", 0, 1, 8, 0, 32'hAB);
    rd("r8_fwd", 1, 2, 8, 12, 0);
    check();
    step();
    rd("r8_disp_wins", 0, 1, 8, 12, 32'hAB);
    check();

    // commit collision: highest lane wins for bypass and write
    cmt(0, 10, 0, 32'h1);
    cmt(1, 10, 0, 32'h2);
    rd("r10_byp_hi", 1, 1, 10, 0, 32'h2);
    check();
    step();
    rd("r10_hi", 0, 2, 10, 0, 32'h2);
    check();

    // flush clears tags, keeps commit data, ignores dispatch
    dsp(0, 2, 6);
    step();
    bus.flush = 1'b1;
    cmt(0, 2, 1, 32'h77);
    dsp(0, 9, 13);
    step();
    rd("flush_r2", 0, 1, 2, 0, 32'h77);
    rd("flush_r9", 0, 2, 9, 0, 0);
    rd("flush_r4", 1, 1, 4, 0, 0);
    rd("flush_r8", 1, 2, 8, 0, 32'hAB);
    check();

    // rdy=0 freezes state
    bus.rdy = 1'b0;
    dsp(0, 5, 10);
    cmt(0, 5, 0, 32'h99);
    step();
    rd("rdy0_r5", 0, 1, 5, 0, 0);
    check();

    // asynchronous reset mid-cycle
    dsp(0, 7, 3);
    step();
    rd("pre_rst_r7", 0, 1, 7, 3, 0);
    check();
    #2 rst = 1'b0;
    rd("async_r7", 0, 1, 7, 0, 0);
    rd("async_r2", 1, 1, 2, 0, 0);
    check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
